// File: rtl/clk_en_monitor.sv
// clk_en_monitor: runtime checker for a single-cycle clock-enable strobe.
// Measures the sys_clk period between pclk_en pulses, declares lock after
// LOCK_CNT consecutive correct periods, and records loss-of-lock events in a
// sticky fault flag and a saturating error counter.
// Optional feature macro: CLK_EN_MON_IRQ_EN adds a 1-cycle irq pulse on every
// loss-of-lock event.
module clk_en_monitor #(
    parameter int PERIOD   = 4,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8,
    localparam int TMO     = 2 * PERIOD,
    localparam int CNT_W   = $clog2(2 * PERIOD + 1)
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             mon_en,
    input  logic             pclk_en,
    input  logic             err_clr,
    output logic             locked,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt,
`ifdef CLK_EN_MON_IRQ_EN
    output logic             irq,
`endif
    output logic [CNT_W-1:0] last_period
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  PERIOD_C = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]  TMO_C    = CNT_W'(TMO);
    localparam logic [CNT_W-1:0]  TMO_M1   = CNT_W'(TMO - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [GOOD_W-1:0] LOCK_C   = GOOD_W'(LOCK_CNT);
    localparam logic [GOOD_W-1:0] LOCK_M1  = GOOD_W'(LOCK_CNT - 1);
    localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);
    localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [GOOD_W-1:0] good;

    logic ev_timeout;
    logic ev_good;
    logic ev_bad;

    // Classify the current cycle: a correctly spaced strobe, a wrongly spaced
    // strobe, or the single cycle where the counter runs into the timeout.
    always_comb begin
        ev_timeout = !pclk_en && (cnt == TMO_M1);
        ev_good    = pclk_en && (cnt == PERIOD_C);
        ev_bad     = (pclk_en && (cnt != PERIOD_C)) || ev_timeout;
    end

    // Monitor state machine with period counter, lock tracking and error log.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            good        <= '0;
            locked      <= 1'b0;
            fault       <= 1'b0;
            err_cnt     <= '0;
            last_period <= '0;
`ifdef CLK_EN_MON_IRQ_EN
            irq         <= 1'b0;
`endif
        end else begin
`ifdef CLK_EN_MON_IRQ_EN
            irq <= 1'b0;
`endif
            if (err_clr) begin
                fault   <= 1'b0;
                err_cnt <= '0;
            end
            if (!mon_en) begin
                state  <= IDLE;
                cnt    <= '0;
                good   <= '0;
                locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ACQ;
                    end
                    ACQ: begin
                        if (pclk_en) begin
                            cnt   <= CNT_ONE;
                            good  <= '0;
                            state <= CHECK;
                        end
                    end
                    CHECK, LOCKED: begin
                        if (pclk_en) begin
                            last_period <= cnt;
                            cnt         <= CNT_ONE;
                        end else if (cnt != TMO_C) begin
                            cnt <= cnt + CNT_ONE;
                            if (ev_timeout) begin
                                last_period <= TMO_C;
                            end
                        end
                        if (state == CHECK) begin
                            if (ev_good) begin
                                if (good == LOCK_M1) begin
                                    good   <= LOCK_C;
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end else begin
                                    good <= good + GOOD_ONE;
                                end
                            end else if (ev_bad) begin
                                good <= '0;
                            end
                        end else if (ev_bad) begin
                            state  <= CHECK;
                            good   <= '0;
                            locked <= 1'b0;
                            fault  <= 1'b1;
                            if (err_clr) begin
                                err_cnt <= ERR_ONE;
                            end else if (err_cnt != ERR_MAX) begin
                                err_cnt <= err_cnt + ERR_ONE;
                            end
`ifdef CLK_EN_MON_IRQ_EN
                            irq <= 1'b1;
`endif
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
